// File: rtl/nexus_clint.sv
// nexus_clint: CLINT-style machine timer / software interrupt block (mtime, mtimecmp, msip).
// Optional build macro CLINT_MTIME_WR_EN makes mtime lo/hi writable from the bus.
module nexus_clint #(
   parameter int unsigned ADDR_W   = 16,
   parameter int unsigned TICK_DIV = 1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_we,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [31:0]       req_wdata,
   input  logic [3:0]        req_wstrb,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic [31:0]       rsp_rdata,
   output logic              rsp_err,
   output logic              timer_irq,
   output logic              software_irq
);

   localparam int unsigned PS_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam int unsigned WA_W = ADDR_W - 2;

   localparam logic [WA_W-1:0] OFF_MSIP   = WA_W'(32'h0000_0000 >> 2);
   localparam logic [WA_W-1:0] OFF_CMP_LO = WA_W'(32'h0000_4000 >> 2);
   localparam logic [WA_W-1:0] OFF_CMP_HI = WA_W'(32'h0000_4004 >> 2);
   localparam logic [WA_W-1:0] OFF_MT_LO  = WA_W'(32'h0000_BFF8 >> 2);
   localparam logic [WA_W-1:0] OFF_MT_HI  = WA_W'(32'h0000_BFFC >> 2);

   logic [63:0]     r_mtime;
   logic [63:0]     r_mtimecmp;
   logic            r_msip;
   logic [PS_W-1:0] r_presc;
   logic            r_rsp_valid;
   logic [31:0]     r_rsp_rdata;
   logic            r_rsp_err;
   logic            r_timer_irq;

   logic [WA_W-1:0] w_word;
   logic            w_accept;
   logic            w_wr;
   logic            w_sel_msip;
   logic            w_sel_cmp_lo;
   logic            w_sel_cmp_hi;
   logic            w_sel_mt_lo;
   logic            w_sel_mt_hi;
   logic            w_hit;
   logic            w_tick;
   logic            w_mt_wr;
   logic [31:0]     w_rdata;
   logic [63:0]     w_mtime_nxt;
   logic            w_unused;

   // Per-byte write merge of new data into an existing 32-bit word.
   function automatic logic [31:0] f_merge(input logic [31:0] old_val,
                                           input logic [31:0] wdata,
                                           input logic [3:0]  strb);
      logic [31:0] res;
      res = old_val;
      for (int b = 0; b < 4; b++) begin
         if (strb[b]) res[b*8 +: 8] = wdata[b*8 +: 8];
      end
      return res;
   endfunction

   assign w_word       = req_addr[ADDR_W-1:2];
   assign w_unused     = ^req_addr[1:0];
   assign req_ready    = !r_rsp_valid || rsp_ready;
   assign w_accept     = req_valid && req_ready;
   assign w_wr         = w_accept && req_we;

   assign w_sel_msip   = (w_word == OFF_MSIP);
   assign w_sel_cmp_lo = (w_word == OFF_CMP_LO);
   assign w_sel_cmp_hi = (w_word == OFF_CMP_HI);
   assign w_sel_mt_lo  = (w_word == OFF_MT_LO);
   assign w_sel_mt_hi  = (w_word == OFF_MT_HI);
   assign w_hit        = w_sel_msip || w_sel_cmp_lo || w_sel_cmp_hi ||
                         w_sel_mt_lo || w_sel_mt_hi;

   assign w_tick       = (r_presc == PS_W'(TICK_DIV - 1));

`ifdef CLINT_MTIME_WR_EN
   assign w_mt_wr = w_wr && (w_sel_mt_lo || w_sel_mt_hi) && (|req_wstrb);
`else
   assign w_mt_wr = 1'b0;
`endif

   // Read mux samples register state as it stands at the accept edge.
   always_comb begin
      w_rdata = '0;
      if (w_sel_msip)        w_rdata = {31'd0, r_msip};
      else if (w_sel_cmp_lo) w_rdata = r_mtimecmp[31:0];
      else if (w_sel_cmp_hi) w_rdata = r_mtimecmp[63:32];
      else if (w_sel_mt_lo)  w_rdata = r_mtime[31:0];
      else if (w_sel_mt_hi)  w_rdata = r_mtime[63:32];
   end

   // A bus write to mtime overrides the tick for that cycle.
   always_comb begin
      w_mtime_nxt = r_mtime;
      if (w_mt_wr) begin
         if (w_sel_mt_lo) w_mtime_nxt[31:0]  = f_merge(r_mtime[31:0],  req_wdata, req_wstrb);
         else             w_mtime_nxt[63:32] = f_merge(r_mtime[63:32], req_wdata, req_wstrb);
      end else if (w_tick) begin
         w_mtime_nxt = r_mtime + 64'd1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_mtime     <= '0;
         r_mtimecmp  <= '1;
         r_msip      <= 1'b0;
         r_presc     <= '0;
         r_timer_irq <= 1'b0;
      end else begin
         r_presc     <= w_tick ? '0 : r_presc + PS_W'(1);
         r_mtime     <= w_mtime_nxt;
         r_timer_irq <= (r_mtime >= r_mtimecmp);
         if (w_wr && w_sel_msip && req_wstrb[0]) r_msip <= req_wdata[0];
         if (w_wr && w_sel_cmp_lo)
            r_mtimecmp[31:0]  <= f_merge(r_mtimecmp[31:0],  req_wdata, req_wstrb);
         if (w_wr && w_sel_cmp_hi)
            r_mtimecmp[63:32] <= f_merge(r_mtimecmp[63:32], req_wdata, req_wstrb);
      end
   end

   // Response slot: filled on accept, held until the consumer takes it.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_rsp_valid <= 1'b0;
         r_rsp_rdata <= '0;
         r_rsp_err   <= 1'b0;
      end else if (w_accept) begin
         r_rsp_valid <= 1'b1;
         r_rsp_rdata <= (req_we || !w_hit) ? 32'd0 : w_rdata;
         r_rsp_err   <= !w_hit;
      end else if (rsp_ready) begin
         r_rsp_valid <= 1'b0;
      end
   end

   assign rsp_valid    = r_rsp_valid;
   assign rsp_rdata    = r_rsp_rdata;
   assign rsp_err      = r_rsp_err;
   assign timer_irq    = r_timer_irq;
   assign software_irq = r_msip;

endmodule

// File: tb/tb_nexus_clint.sv
// Self-checking bench for nexus_clint: directed scenarios plus random bus traffic
// checked every cycle against a transaction-level model of the register map.
module tb_nexus_clint;
   localparam int unsigned ADDR_W   = 16;
   localparam int unsigned TICK_DIV = 1;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        req_valid, req_ready, req_we;
   logic [15:0] req_addr;
   logic [31:0] req_wdata;
   logic [3:0]  req_wstrb;
   logic        rsp_valid, rsp_ready;
   logic [31:0] rsp_rdata;
   logic        rsp_err, timer_irq, software_irq;

   int n_checks = 0;
   int n_fail   = 0;
   bit chk_on   = 1'b0;

   always #5 clk = ~clk;

   nexus_clint #(.ADDR_W(ADDR_W), .TICK_DIV(TICK_DIV)) dut (
      .clk(clk), .rst_n(rst_n),
      .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
      .req_addr(req_addr), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
      .rsp_err(rsp_err), .timer_irq(timer_irq), .software_irq(software_irq)
   );

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   logic [63:0]     m_mtime, m_cmp, m_tmp;
   logic            m_msip, m_rv, m_err, m_tirq;
   logic [31:0]     m_rdata, m_mask;
   logic [32:0]     m_rr;
   logic            m_acc, m_tick, m_mtw;
   longint unsigned m_edges;

   function automatic logic [32:0] m_read(input logic [15:0] a);
      logic [15:0] w;
      w = {a[15:2], 2'b00};
      case (w)
         16'h0000: return {1'b0, 31'd0, m_msip};
         16'h4000: return {1'b0, m_cmp[31:0]};
         16'h4004: return {1'b0, m_cmp[63:32]};
         16'hBFF8: return {1'b0, m_mtime[31:0]};
         16'hBFFC: return {1'b0, m_mtime[63:32]};
         default:  return {1'b1, 32'd0};
      endcase
   endfunction

   function automatic logic [31:0] bmask(input logic [3:0] s);
      return {{8{s[3]}}, {8{s[2]}}, {8{s[1]}}, {8{s[0]}}};
   endfunction

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_mtime = 64'd0; m_cmp = '1; m_msip = 1'b0;
         m_rv = 1'b0; m_rdata = 32'd0; m_err = 1'b0; m_tirq = 1'b0; m_edges = 0;
      end else begin
         m_acc  = req_valid && (!m_rv || rsp_ready);
         m_tick = (m_edges % TICK_DIV) == longint'(TICK_DIV - 1);
         m_edges++;
         m_mtw  = 1'b0;
         m_tmp  = m_mtime;
         m_rr   = m_read(req_addr);
         m_mask = bmask(req_wstrb);
         m_tirq = (m_mtime >= m_cmp);
         if (m_acc) begin
            m_rv    = 1'b1;
            m_err   = m_rr[32];
            m_rdata = req_we ? 32'd0 : m_rr[31:0];
            if (req_we) begin
               case ({req_addr[15:2], 2'b00})
                  16'h0000: if (req_wstrb[0]) m_msip = req_wdata[0];
                  16'h4000: m_cmp[31:0]  = (m_cmp[31:0]  & ~m_mask) | (req_wdata & m_mask);
                  16'h4004: m_cmp[63:32] = (m_cmp[63:32] & ~m_mask) | (req_wdata & m_mask);
`ifdef CLINT_MTIME_WR_EN
                  16'hBFF8: if (|req_wstrb) begin
                     m_tmp[31:0] = (m_tmp[31:0] & ~m_mask) | (req_wdata & m_mask);
                     m_mtw = 1'b1;
                  end
                  16'hBFFC: if (|req_wstrb) begin
                     m_tmp[63:32] = (m_tmp[63:32] & ~m_mask) | (req_wdata & m_mask);
                     m_mtw = 1'b1;
                  end
`endif
                  default: ;
               endcase
            end
         end else if (rsp_ready) begin
            m_rv = 1'b0;
         end
         m_mtime = m_mtw ? m_tmp : (m_tick ? m_mtime + 64'd1 : m_mtime);
      end
   end

   // Per-cycle comparison against the model.
   always @(negedge clk) begin
      if (chk_on) begin
         chk("rsp_valid", rsp_valid, m_rv);
         chk("req_ready", req_ready, !m_rv || rsp_ready);
         if (m_rv) begin
            chk("rsp_rdata", rsp_rdata, m_rdata);
            chk("rsp_err", rsp_err, m_err);
         end
         chk("timer_irq", timer_irq, m_tirq);
         chk("software_irq", software_irq, m_msip);
      end
   end

   // One accepted request with rsp_ready high; returns the response seen one edge later.
   task automatic bus(input logic we, input logic [15:0] a, input logic [31:0] d,
                      input logic [3:0] s, output logic [31:0] rd, output logic er);
      @(negedge clk); #1;
      req_valid = 1'b1; req_we = we; req_addr = a; req_wdata = d; req_wstrb = s;
      @(negedge clk);
      rd = rsp_rdata; er = rsp_err;
      #1 req_valid = 1'b0;
   endtask

   function automatic logic [15:0] pick_addr();
      logic [15:0] base;
      case ($urandom_range(0, 6))
         0: base = 16'h0000;
         1: base = 16'h4000;
         2: base = 16'h4004;
         3: base = 16'hBFF8;
         4: base = 16'hBFFC;
         5: base = 16'h0100;
         default: base = 16'($urandom);
      endcase
      return base | 16'($urandom_range(0, 3));
   endfunction

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1);
   end

   initial begin
      logic [31:0] d;
      logic        e;
      rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_addr = '0;
      req_wdata = '0; req_wstrb = '0; rsp_ready = 1'b1;
      @(posedge clk);
      chk_on = 1'b1;
      @(negedge clk);
      chk("rst_rsp_valid", rsp_valid, 0);
      chk("rst_rsp_rdata", rsp_rdata, 0);
      chk("rst_timer_irq", timer_irq, 0);
      chk("rst_sw_irq", software_irq, 0);
      #1 rst_n = 1'b1;

      bus(0, 16'h4000, 0, 0, d, e);
      chk("cmp_lo_reset", d, 32'hFFFF_FFFF); chk("cmp_lo_err", e, 0);
      bus(0, 16'h4004, 0, 0, d, e);
      chk("cmp_hi_reset", d, 32'hFFFF_FFFF);

      bus(1, 16'h0000, 32'h1, 4'h1, d, e);
      chk("msip_set_irq", software_irq, 1); chk("wr_rdata_zero", d, 0);
      bus(0, 16'h0002, 0, 0, d, e);
      chk("msip_readback", d, 1);
      bus(1, 16'h0000, 32'h0, 4'hF, d, e);
      chk("msip_clr_irq", software_irq, 0);

      bus(1, 16'h4000, 32'd10, 4'hF, d, e);
      bus(1, 16'h4004, 32'd0, 4'hF, d, e);
      chk("tirq_lag", timer_irq, 0);
      @(negedge clk);
      chk("tirq_rise", timer_irq, 1);
      bus(0, 16'hBFF8, 0, 0, d, e);
      chk("mtime_ge_10", (d >= 32'd10), 1);
      bus(1, 16'h4004, 32'hFFFF_FFFF, 4'hF, d, e);
      chk("tirq_hold_1", timer_irq, 1);
      @(negedge clk);
      chk("tirq_fall_2", timer_irq, 0);
      bus(1, 16'h4000, 32'hFFFF_FFFF, 4'hF, d, e);

`ifdef CLINT_MTIME_WR_EN
      bus(1, 16'hBFFC, 32'hFFFF_FFFF, 4'hF, d, e);
      bus(1, 16'hBFF8, 32'hFFFF_FFFE, 4'hF, d, e);
      bus(0, 16'hBFF8, 0, 0, d, e);
      chk("mtime_pre_wrap_lo", d, 32'hFFFF_FFFF);
      bus(0, 16'hBFFC, 0, 0, d, e);
      chk("mtime_wrap_hi", d, 32'h0);
`else
      bus(1, 16'hBFF8, 32'h0, 4'hF, d, e);
      chk("mtime_ro_err", e, 0);
`endif

      // Unmapped read with the response stalled for three cycles.
      @(negedge clk); #1;
      rsp_ready = 1'b0; req_valid = 1'b1; req_we = 1'b0; req_addr = 16'h0100;
      @(negedge clk); #1 req_valid = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("err_hold_valid", rsp_valid, 1);
         chk("err_hold_err", rsp_err, 1);
         chk("err_hold_rdata", rsp_rdata, 0);
         chk("err_hold_ready", req_ready, 0);
      end
      #1 rsp_ready = 1'b1;
      @(negedge clk);
      chk("err_consumed", rsp_valid, 0);

      for (int i = 0; i < 2000; i++) begin
         @(negedge clk); #1;
         req_valid = ($urandom_range(0, 1) == 1);
         req_we    = ($urandom_range(0, 1) == 1);
         req_addr  = pick_addr();
         req_wdata = $urandom;
         req_wstrb = 4'($urandom);
         rsp_ready = ($urandom_range(0, 3) != 0);
      end
      @(negedge clk); #1;
      req_valid = 1'b0; rsp_ready = 1'b1;
      repeat (2) @(negedge clk);

      // Reset while a response is pending and both interrupts are up.
      bus(1, 16'h0000, 32'h1, 4'hF, d, e);
      bus(1, 16'h4000, 32'h0, 4'hF, d, e);
      bus(1, 16'h4004, 32'h0, 4'hF, d, e);
      repeat (2) @(negedge clk);
      chk("pre_rst_tirq", timer_irq, 1);
      chk("pre_rst_sirq", software_irq, 1);
      #1 rsp_ready = 1'b0; req_valid = 1'b1; req_we = 1'b0; req_addr = 16'h4000;
      @(negedge clk);
      chk("pre_rst_valid", rsp_valid, 1);
      #1 rst_n = 1'b0; req_valid = 1'b0;
      #1;
      chk("mid_rst_valid", rsp_valid, 0);
      chk("mid_rst_tirq", timer_irq, 0);
      chk("mid_rst_sirq", software_irq, 0);
      repeat (2) @(negedge clk);
      #1 rst_n = 1'b1; rsp_ready = 1'b1;
      bus(0, 16'h4004, 0, 0, d, e);
      chk("post_rst_cmp_hi", d, 32'hFFFF_FFFF);
      repeat (2) @(negedge clk);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
